// File: rtl/signal_capture.sv
// signal_capture: triggered sample-capture buffer.
// Waits (ARMED) for a rising crossing of i_trig_level, then records
// DEPTH = 2**NB_ADDR valid samples into RAM starting at address 0.
// The captured window is read back through a registered read port.
// Optional feature macro: SIGNAL_CAPTURE_PEAK_EN adds signed running
// max/min of the captured window (o_peak_max / o_peak_min).
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | after reset, waiting for i_arm
// ST_ARMED   | tracking previous sample, waiting for a level crossing
// ST_CAPTURE | writing each valid sample at address o_count
// ST_DONE    | window full, holding until re-armed
module signal_capture #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 10
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic signed [NB_DATA-1:0] i_data,
    input  logic                      i_valid,
    input  logic                      i_arm,
    input  logic signed [NB_DATA-1:0] i_trig_level,
    input  logic        [NB_ADDR-1:0] i_rd_addr,
    output logic signed [NB_DATA-1:0] o_rd_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic        [NB_ADDR:0]   o_count
`ifdef SIGNAL_CAPTURE_PEAK_EN
    ,
    output logic signed [NB_DATA-1:0] o_peak_max,
    output logic signed [NB_DATA-1:0] o_peak_min
`endif
);

    localparam int DEPTH = 1 << NB_ADDR;
    localparam logic [NB_ADDR:0] LAST_IDX = (NB_ADDR+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t state, state_next;

    logic signed [NB_DATA-1:0] prev_data;
    logic                      prev_valid;
    logic                      trigger;
    logic                      arm_accept;
    logic                      wr_en;
    logic        [NB_ADDR-1:0] wr_addr;

    logic signed [NB_DATA-1:0] mem [DEPTH];

    // State register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, trigger detection and RAM write control
    always_comb begin
        state_next = state;
        trigger    = 1'b0;
        arm_accept = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = o_count[NB_ADDR-1:0];
        case (state)
            ST_IDLE: begin
                if (i_arm) begin
                    arm_accept = 1'b1;
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // A crossing needs a prior sample, so the first one after arming cannot fire.
                if (i_valid && prev_valid &&
                    (prev_data < i_trig_level) && (i_data >= i_trig_level)) begin
                    trigger    = 1'b1;
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (i_valid) begin
                    wr_en = 1'b1;
                    if (o_count == LAST_IDX) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (i_arm) begin
                    arm_accept = 1'b1;
                    state_next = ST_ARMED;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Sample counter and previous-sample tracking
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_count    <= '0;
            prev_data  <= '0;
            prev_valid <= 1'b0;
        end else if (arm_accept) begin
            o_count    <= '0;
            prev_valid <= 1'b0;
        end else if (state == ST_ARMED && i_valid) begin
            prev_data  <= i_data;
            prev_valid <= 1'b1;
            if (trigger) begin
                o_count <= (NB_ADDR+1)'(1);
            end
        end else if (state == ST_CAPTURE && i_valid) begin
            o_count <= o_count + (NB_ADDR+1)'(1);
        end
    end

    // Status flags decoded from the state
    always_comb begin
        o_busy = (state == ST_ARMED) || (state == ST_CAPTURE);
        o_done = (state == ST_DONE);
    end

    // Capture RAM write port; contents survive reset
    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            mem[wr_addr] <= i_data;
        end
    end

    // Registered read port; same-address write in the same cycle returns old data
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_rd_data <= '0;
        end else begin
            o_rd_data <= mem[i_rd_addr];
        end
    end

`ifdef SIGNAL_CAPTURE_PEAK_EN
    // Running signed max/min of the window, seeded by the trigger sample
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_peak_max <= '0;
            o_peak_min <= '0;
        end else if (trigger) begin
            o_peak_max <= i_data;
            o_peak_min <= i_data;
        end else if (state == ST_CAPTURE && i_valid) begin
            if (i_data > o_peak_max) begin
                o_peak_max <= i_data;
            end
            if (i_data < o_peak_min) begin
                o_peak_min <= i_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_signal_capture.sv
// tb_signal_capture: randomized scoreboard bench for signal_capture.
// A driver steps a window-level reference model each cycle and queues the
// expected status and read data; a monitor pops and compares after each edge.
module tb_signal_capture;

    localparam int NB_DATA = 8;
    localparam int NB_ADDR = 10;
    localparam int DEPTH   = 1 << NB_ADDR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst_n;
    logic signed [NB_DATA-1:0] i_data;
    logic                      i_valid;
    logic                      i_arm;
    logic signed [NB_DATA-1:0] i_trig_level;
    logic        [NB_ADDR-1:0] i_rd_addr;
    logic signed [NB_DATA-1:0] rd_data;
    logic                      busy;
    logic                      done;
    logic        [NB_ADDR:0]   count;
`ifdef SIGNAL_CAPTURE_PEAK_EN
    logic signed [NB_DATA-1:0] peak_max;
    logic signed [NB_DATA-1:0] peak_min;
`endif

    signal_capture #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .i_arm        (i_arm),
        .i_trig_level (i_trig_level),
        .i_rd_addr    (i_rd_addr),
        .o_rd_data    (rd_data),
        .o_busy       (busy),
        .o_done       (done),
        .o_count      (count)
`ifdef SIGNAL_CAPTURE_PEAK_EN
        ,
        .o_peak_max   (peak_max),
        .o_peak_min   (peak_min)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    bit  m_armed;
    int  win[$];
    int  m_prev;
    bit  m_pv;
    int  m_pmax, m_pmin;
    int  mem_m[DEPTH];
    int  hi;
    int  level;

    function automatic bit m_busy();
        return m_armed || (win.size() > 0 && win.size() < DEPTH);
    endfunction

    function automatic bit m_done();
        return win.size() == DEPTH;
    endfunction

    function automatic void m_push(input int d);
        mem_m[win.size()] = d;
        if (win.size() == 0) begin
            m_pmax = d;
            m_pmin = d;
        end else begin
            if (d > m_pmax) m_pmax = d;
            if (d < m_pmin) m_pmin = d;
        end
        win.push_back(d);
        if (win.size() > hi) hi = win.size();
    endfunction

    function automatic void m_reset();
        m_armed = 0;
        win.delete();
        m_pv   = 0;
        m_prev = 0;
        m_pmax = 0;
        m_pmin = 0;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        int busy;
        int done;
        int count;
        int pmax;
        int pmin;
    } st_exp_t;

    st_exp_t st_q[$];
    int      rd_q[$];
    bit      st_req = 0;
    bit      rd_req = 0;

    initial begin
        bit s, r;
        st_exp_t e;
        forever begin
            @(posedge clk);
            s = st_req;
            r = rd_req;
            #1;
            if (s) begin
                if (st_q.size() == 0) check("status_queue_underflow", 0, 1);
                else begin
                    e = st_q.pop_front();
                    check("busy", int'(busy), e.busy);
                    check("done", int'(done), e.done);
                    check("count", int'(count), e.count);
`ifdef SIGNAL_CAPTURE_PEAK_EN
                    check("peak_max", int'(peak_max), e.pmax);
                    check("peak_min", int'(peak_min), e.pmin);
`endif
                end
            end
            if (r) begin
                if (rd_q.size() == 0) check("read_queue_underflow", 0, 1);
                else check("rd_data", int'(rd_data), rd_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input bit arm, input bit valid, input int d,
                        input int force_addr = -1, input int force_exp = 0);
        int      addr;
        int      exp_rd;
        bit      cap;
        st_exp_t e;
        @(negedge clk);
        i_arm        = arm;
        i_valid      = valid;
        i_data       = d[NB_DATA-1:0];
        i_trig_level = level[NB_DATA-1:0];
        cap  = !m_armed && win.size() > 0 && win.size() < DEPTH;
        addr = -1;
        exp_rd = 0;
        if (force_addr >= 0) begin
            addr   = force_addr;
            exp_rd = force_exp;
        end else if (hi > 0) begin
            if (cap && valid && win.size() < hi && $urandom_range(0, 3) == 0)
                addr = win.size();
            else
                addr = int'($urandom_range(0, hi - 1));
            exp_rd = mem_m[addr];
        end
        if (addr >= 0) begin
            i_rd_addr = addr[NB_ADDR-1:0];
            rd_q.push_back(exp_rd);
            rd_req = 1;
        end else begin
            rd_req = 0;
        end
        // model update
        if (arm && !m_busy()) begin
            m_armed = 1;
            win.delete();
            m_pv = 0;
        end else if (m_armed) begin
            if (valid) begin
                if (m_pv && m_prev < level && d >= level) begin
                    m_armed = 0;
                    m_push(d);
                end
                m_prev = d;
                m_pv   = 1;
            end
        end else if (cap && valid) begin
            m_push(d);
        end
        e.busy  = m_busy();
        e.done  = m_done();
        e.count = win.size();
        e.pmax  = m_pmax;
        e.pmin  = m_pmin;
        st_q.push_back(e);
        st_req = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        st_req  = 0;
        rd_req  = 0;
        i_arm   = 0;
        i_valid = 0;
        #2;
        rst_n = 0;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        check("async_rst_count", int'(count), 0);
        check("async_rst_rd_data", int'(rd_data), 0);
`ifdef SIGNAL_CAPTURE_PEAK_EN
        check("async_rst_peak_max", int'(peak_max), 0);
        check("async_rst_peak_min", int'(peak_min), 0);
`endif
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic int rnd_data();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    initial begin
        int guard;
        rst_n        = 0;
        i_data       = '0;
        i_valid      = 0;
        i_arm        = 0;
        i_trig_level = '0;
        i_rd_addr    = '0;
        hi           = 0;
        level        = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_count", int'(count), 0);
        check("reset_rd_data", int'(rd_data), 0);
        @(negedge clk);
        rst_n = 1;

        // Ramp -5..+5 with level 0, first capture fills the window.
        level = 0;
        step(1, 0, 0);
        for (int v = -5; v <= 5; v++) step(0, 1, v);
        guard = 0;
        while (!m_done() && guard < 3000) begin
            step(0, 1, rnd_data());
            guard++;
        end
        check("ramp_capture_finished", int'(m_done()), 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 2, 2);
        repeat (5) step(0, 1, rnd_data());

        // Re-arm from DONE, then constant input never crosses.
        step(1, 0, 0);
        for (int i = 0; i < 300; i++) step(0, 1, 10);
        step(0, 1, -1);
        step(0, 1, 5);

        // Half-rate valid with stray arm pulses while capturing.
        guard = 0;
        while (!m_done() && guard < 5000) begin
            step(($urandom_range(0, 40) == 0), (guard % 2 == 0), rnd_data());
            guard++;
        end
        check("halfrate_capture_finished", int'(m_done()), 1);
        repeat (4) step(0, 1, rnd_data());

        // Random levels, random valid, resets dropped mid-run.
        for (int round = 0; round < 3; round++) begin
            level = int'($urandom_range(0, 100)) - 50;
            step(1, 1, rnd_data());
            for (int i = 0; i < int'($urandom_range(200, 900)); i++)
                step(($urandom_range(0, 60) == 0), ($urandom_range(0, 9) < 7), rnd_data());
            do_reset();
        end

        // Sine +/-100 captured from IDLE with level 0.
        level = 0;
        step(1, 0, 0);
        guard = 0;
        while (!m_done() && guard < 3000) begin
            step(0, 1, int'(100.0 * $sin(2.0 * 3.14159265358979 * real'(guard + 20) / 40.0)));
            guard++;
        end
        check("sine_capture_finished", int'(m_done()), 1);
        repeat (3) step(0, 1, rnd_data());
`ifdef SIGNAL_CAPTURE_PEAK_EN
        @(negedge clk);
        check("sine_peak_max", int'(peak_max), 100);
        check("sine_peak_min", int'(peak_min), -100);
`endif

        @(negedge clk);
        st_req = 0;
        rd_req = 0;
        @(posedge clk);
        #3;
        check("status_queue_drained", st_q.size(), 0);
        check("read_queue_drained", rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
